// File: rtl/clk_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_unit
// Brief    : Lock-gated multi-channel clock-enable generator with
//            phase-aligned, handshaked divisor reloads.
// Revision : 1.0
// ============================================================================
module clk_div_unit #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    pll_locked_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic                    load_i,
  output logic                    load_ack_o,
  output logic                    pending_o,
  output logic                    locked_o,
  output logic [NUM_CH-1:0]       ce_o
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ack;
  logic [CNT_W-1:0]       r_cnt [NUM_CH];
  logic [CNT_W-1:0]       r_act [NUM_CH];
  logic [CNT_W-1:0]       r_shd [NUM_CH];

  logic w_active;
  logic w_wrap0;
  logic w_clear;
  logic w_load_now;
  logic w_apply;
  logic w_capture;
  logic w_ack_nxt;

  assign locked_o   = r_sync[SYNC_STAGES-1];
  assign pending_o  = (r_state == ST_PEND);
  assign load_ack_o = r_ack;
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_PEND);
  assign w_wrap0    = (r_cnt[0] == r_act[0]);

  // Lock loss has priority; any outstanding request is applied on entry to WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_load_now  = 1'b0;
    w_apply     = 1'b0;
    w_capture   = 1'b0;
    w_ack_nxt   = 1'b0;
    case (r_state)
      ST_WAIT: begin
        w_clear = 1'b1;
        if (load_i) begin
          w_load_now = 1'b1;
          w_ack_nxt  = 1'b1;
        end
        if (locked_o) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_o) begin
          w_state_nxt = ST_WAIT;
          w_clear     = 1'b1;
          if (load_i) begin
            w_load_now = 1'b1;
            w_ack_nxt  = 1'b1;
          end
        end else if (load_i) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!locked_o) begin
          w_state_nxt = ST_WAIT;
          w_clear     = 1'b1;
          w_ack_nxt   = 1'b1;
          w_load_now  = load_i;
          w_apply     = !load_i;
        end else if (w_wrap0) begin
          w_apply     = 1'b1;
          w_clear     = 1'b1;
          w_ack_nxt   = 1'b1;
          w_capture   = load_i;
          w_state_nxt = load_i ? ST_PEND : ST_RUN;
        end else begin
          w_capture = load_i;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT;
        w_clear     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_state <= ST_WAIT;
      r_ack   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pll_locked_i};
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_cnt[k] <= '0;
        r_act[k] <= C_DEFAULT_DIV;
        r_shd[k] <= C_DEFAULT_DIV;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_clear || (r_cnt[k] == r_act[k])) begin
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
        if (w_load_now) begin
          r_act[k] <= div_i[k*CNT_W +: CNT_W];
          r_shd[k] <= div_i[k*CNT_W +: CNT_W];
        end else begin
          // Apply reads the old shadow even when a new capture lands on the same edge.
          if (w_apply)   r_act[k] <= r_shd[k];
          if (w_capture) r_shd[k] <= div_i[k*CNT_W +: CNT_W];
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ce
      assign ce_o[k] = w_active && (r_cnt[k] == r_act[k]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/clk_div_unit.md
# clk_div_unit

Parametrised clock-enable generator. It runs on the single fast PLL clock and produces NUM_CH independent one-cycle clock enables, each with its own runtime-programmable divide ratio. It replaces fixed ripple/toggle dividers with enables, so all downstream logic stays in one clock domain. It sits directly after the PLL and feeds the USB SIE, the CPU and the peripherals. It gates everything on PLL lock and supports glitch-free, phase-aligned ratio changes (for example, switching between low-speed and full-speed bit rates) through a load/ack handshake.

## Interface
Parameters:
- NUM_CH, 2: number of enable channels (1..8).
- CNT_W, 8: width of each divisor and counter.
- DEFAULT_DIV, 1: divisor loaded into every channel at reset (ratio = DEFAULT_DIV+1).
- SYNC_STAGES, 2: synchroniser depth for pll_locked_i (≥2).

Ports:
- clk_i  in  1  single clock (PLL output). All logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pll_locked_i  in  1  PLL lock; asynchronous to clk_i, synchronised internally.
- div_i  in  NUM_CH*CNT_W  requested divisors; channel k is in bits [k*CNT_W +: CNT_W].
- load_i  in  1  single-cycle request to adopt div_i.
- load_ack_o  out  1  single-cycle pulse when the requested divisors take effect.
- pending_o  out  1  a load has been captured but not yet applied.
- locked_o  out  1  synchronised lock status.
- ce_o  out  NUM_CH  per-channel clock enable; one cycle high every div_k+1 cycles.

## Operation
- Registers:
  - lock synchroniser;
  - state;
  - per channel: counter cnt_k, active divisor act_k, shadow divisor shd_k.
- Reset values:
  - state WAIT;
  - cnt_k = 0, act_k = shd_k = DEFAULT_DIV;
  - ce_o = 0, load_ack_o = 0, pending_o = 0, locked_o = 0.
- locked_o is the output of the SYNC_STAGES-deep synchroniser on pll_locked_i.
- States:
  - WAIT:
    - all cnt_k held at 0 and ce_o = 0.
    - locked_o = 1 → RUN next cycle.
    - load_i → shd_k = act_k = div_i immediately; load_ack_o pulses the next cycle; no pending.
  - RUN:
    - cnt_k increments each cycle and wraps to 0 when cnt_k == act_k.
    - ce_o[k] = (cnt_k == act_k) && state ∈ {RUN, PEND}, decoded from registers only.
    - load_i → capture div_i into shd_k, pending_o = 1, → PEND.
  - PEND:
    - counting continues with the old act_k.
    - At the channel-0 wrap cycle (cnt_0 == act_0), ce_o fires with the old ratios. In that same edge, act_k = shd_k and all cnt_k = 0 (every channel realigns to phase 0), load_ack_o = 1 in the next cycle, pending_o = 0, → RUN.
- Divisor arithmetic:
  - Unsigned; ratio = div+1.
  - div = 0 gives ce_o high every cycle.
  - div = 2^CNT_W−1 gives a period of 2^CNT_W.
  - Counters never exceed act_k.
- Boundary cases:
  - load_i in PEND: shd_k is overwritten (last request wins); one ack only.
  - load_i in the channel-0 wrap cycle while in RUN: captured, applied at the following wrap (never the current one).
  - load_i in the same cycle as the PEND apply: the apply completes with the old shadow; the new request is captured → PEND again.
  - locked_o falls in RUN or PEND:
    - → WAIT next cycle; ce_o = 0 immediately after; cnt cleared.
    - A pending shadow is applied on entry to WAIT (act_k = shd_k), with ack the next cycle and pending_o = 0.
  - reset asserted at any time clears all state asynchronously; no ce pulse or ack is emitted during reset.

## Timing
- pll_locked_i rise → locked_o high after SYNC_STAGES to SYNC_STAGES+1 cycles.
- locked_o high → RUN on the next edge.
- In RUN, the first ce_o[k] occurs in RUN cycle act_k+1 (counted from 1). Thereafter the period is exactly act_k+1 cycles.
- load latency: at most act_0+1 cycles from load_i to the apply edge. load_ack_o follows one cycle later.
- After an apply, ce_o[k] next fires exactly new act_k+1 cycles after the apply edge, for all k simultaneously aligned.
- load_ack_o and every ce_o bit are single-cycle pulses. ce_o is never high in WAIT or during reset.

## Test plan
- Reset, pll_locked_i = 1, defaults (DEFAULT_DIV = 1) → ce_o[0], ce_o[1] high every 2nd cycle, first pulse 2 RUN cycles after locked_o rises.
- Run with div 0/7 (ch0/ch1), load div 3/11 mid-period → old ratios hold until cnt_0 == 0; then all counters zero, load_ack_o pulses once, ce_o[0] every 4 cycles, ce_o[1] every 12, phases aligned.
- Two load_i pulses in PEND (div 5, then div 2) → single ack, div 2 applied (period 3).
- Drop pll_locked_i in PEND → ce_o goes 0 within SYNC_STAGES+2 cycles, ack pulses once, relock restarts with the new ratios.
- div = 255 with CNT_W = 8 → period 256, no counter overflow.
- Assert reset mid-period with a load pending → all outputs 0 asynchronously; after release, divisors are back to DEFAULT_DIV.
